bar_sweep_ctrl: RTL
===================

// Module: bar_sweep_ctrl
// PURPOSE
//  Sequencer for the scanline bar renderer. Owns bar position, direction and sweep limits.
//  Advances position once per N frames, only at frame boundaries, so the bar never tears mid-frame.
//  Accepts runtime reconfiguration over a valid/ready handshake. Drives bar_pos/bar_width
//  to the pixel-compare datapath.
// PARAMETERS
//  POS_W         10   width of position/limit/step fields
//  LO_DEFAULT    0    lower sweep limit after reset
//  HI_DEFAULT    620  upper sweep limit after reset
//  STEP_DEFAULT  1    pixels moved per step after reset
//  WIDTH_DEFAULT 20   bar width after reset
//  FRAME_DIV     1    frames per step (>=1)
//  DWELL_FRAMES  30   frames held at a limit (DWELL_EN only)
// PORTS
//  clk          in   1      pixel clock
//  rst_n        in   1      synchronous reset, active low
//  run          in   1      1 = sweep active, 0 = freeze
//  frame_start  in   1      1-cycle pulse at start of vertical blanking
//  cfg_valid    in   1      config request
//  cfg_ready    out  1      config can be accepted this cycle
//  cfg_lo       in   POS_W  new lower limit
//  cfg_hi       in   POS_W  new upper limit
//  cfg_step     in   POS_W  new step size
//  cfg_width    in   POS_W  new bar width
//  cfg_err      out  1      1-cycle pulse: config rejected
//  bar_pos      out  POS_W  current bar left edge
//  bar_width    out  POS_W  current bar width
//  dir          out  1      0 = increasing, 1 = decreasing
//  pos_update   out  1      1-cycle pulse in the cycle bar_pos takes a new value
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, bar_pos=LO_DEFAULT, bar_width=WIDTH_DEFAULT, dir=0,
//  limits/step = defaults, frame_cnt=0, cfg_err=0, pos_update=0. Reset wins over every other input,
//  including mid-STEP.
//  States:
//   IDLE   -> WAIT when run=1.
//   WAIT   counts frame_start pulses. On a pulse with frame_cnt==FRAME_DIV-1: frame_cnt=0, ->STEP;
//          otherwise frame_cnt++. run=0 -> IDLE (bar_pos held, frame_cnt=0).
//   STEP   one cycle: updates bar_pos/dir, asserts pos_update, -> WAIT (or IDLE if run=0).
//  Latency: qualifying frame_start at cycle N -> STEP at N+1 -> new bar_pos and pos_update visible at N+2.
//  frame_start arriving in STEP or IDLE is ignored.
//  Step arithmetic (POS_W+1 bits, no wrap):
//   dir=0: if bar_pos+step >= hi then bar_pos=hi, dir=1, else bar_pos+=step.
//   dir=1: if bar_pos <= lo+step then bar_pos=lo, dir=0, else bar_pos-=step.
//  Config handshake:
//   cfg_ready = (state!=STEP) && rst_n. Transfer occurs when cfg_valid && cfg_ready.
//   Legal config requires cfg_lo < cfg_hi and cfg_step != 0:
//    - Legal: load limits, step and width; clamp bar_pos into [lo,hi]; frame_cnt=0; pos_update pulses
//      if bar_pos changed.
//    - Illegal: keep old config; cfg_err=1 for one cycle.
//   Transfer in the same cycle as frame_start: config applied, that frame_start discarded.
//   Holding cfg_valid high re-applies every ready cycle; this is idempotent.
// CONFIGURATION
//  DWELL_EN defined: the STEP that reaches a limit enters state DWELL, which counts DWELL_FRAMES
//   frame_start pulses (bar_pos held, pos_update low), then goes to WAIT. run=0 in DWELL -> IDLE.
//   cfg_ready is high in DWELL; a legal config exits DWELL to WAIT.
//  DWELL_EN undefined: no DWELL state; direction reverses immediately at the limit.
// TESTING
//  Reset, then run=1 with FRAME_DIV=1: pulse frame_start -> bar_pos 0->1 two cycles later, pos_update 1 cycle.
//  Config lo=10 hi=30 step=7 with bar_pos=0 -> bar_pos=10; frames -> 17, 24, 30 (dir=1), 23, 16, 10 (dir=0).
//  Config lo=50 hi=50 -> cfg_err pulse; limits, bar_pos and dir unchanged.
//  cfg_valid and frame_start in the same cycle -> config applied, no step on that frame.
//  run=0 mid-sweep -> bar_pos frozen over 5 frames; rst_n=0 in STEP -> bar_pos=LO_DEFAULT, dir=0.
//  DWELL_EN with DWELL_FRAMES=3 at hi -> 3 frames with no move, then decrement on the 4th frame.

Source files
------------

// File: rtl/bar_sweep_ctrl_if.sv
// Configuration bus for bar_sweep_ctrl: one request carries the new sweep
// limits, step and bar width; the sequencer answers with ready and a reject pulse.
//
// Handshake: a transfer happens on every rising clk edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_lo/hi/step/width stable while
// cfg_valid is high. cfg_ready does not depend on cfg_valid. cfg_err is a
// one-cycle pulse in the cycle after a rejected transfer.
interface bar_sweep_ctrl_if #(
  parameter int POS_W = 10
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [POS_W-1:0] cfg_lo;
  logic [POS_W-1:0] cfg_hi;
  logic [POS_W-1:0] cfg_step;
  logic [POS_W-1:0] cfg_width;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_lo, cfg_hi, cfg_step, cfg_width,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_lo, cfg_hi, cfg_step, cfg_width,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/bar_sweep_ctrl.sv
// bar_sweep_ctrl: sequencer for the scanline bar renderer. Moves the bar
// between a lower and upper limit, one step per FRAME_DIV frames, and only
// changes position at frame boundaries so the bar never tears mid-frame.
// Limits, step and width can be reconfigured at runtime over the cfg bus.
//
// Optional feature: define DWELL_EN to hold the bar at each limit for
// DWELL_FRAMES frames before it reverses. Without it the bar reverses
// immediately on reaching a limit.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 WAIT, 2 STEP, 3 DWELL.
module bar_sweep_ctrl #(
  parameter int POS_W         = 10,
  parameter int LO_DEFAULT    = 0,
  parameter int HI_DEFAULT    = 620,
  parameter int STEP_DEFAULT  = 1,
  parameter int WIDTH_DEFAULT = 20,
  parameter int FRAME_DIV     = 1
`ifdef DWELL_EN
  , parameter int DWELL_FRAMES = 30
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             frame_start,
  bar_sweep_ctrl_if.slave  cfg,
  output logic [POS_W-1:0] bar_pos,
  output logic [POS_W-1:0] bar_width,
  output logic             dir,
  output logic             pos_update,
  output logic [1:0]       state_dbg
);

`ifdef DWELL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEP = 2'd2, DWELL = 2'd3} state_t;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
  logic [15:0] dwell_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEP = 2'd2} state_t;
`endif

  localparam logic [15:0] FRAME_LAST = 16'(FRAME_DIV - 1);

  state_t           state;
  logic [POS_W-1:0] lo;
  logic [POS_W-1:0] hi;
  logic [POS_W-1:0] step;
  logic [15:0]      frame_cnt;

  logic             cfg_fire;
  logic             cfg_legal;
  logic [POS_W:0]   pos_plus_step;
  logic [POS_W:0]   lo_plus_step;
  logic [POS_W-1:0] next_pos;
  logic             next_dir;
  logic             hit_limit;
  logic [POS_W-1:0] clamp_pos;

  assign state_dbg     = state;
  // No transfer during STEP so a config never races a position update.
  assign cfg.cfg_ready = (state != STEP) && rst_n;
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_legal     = (cfg.cfg_lo < cfg.cfg_hi) && (cfg.cfg_step != '0);

  // Next position and direction for a STEP; one extra bit so sums never wrap.
  always_comb begin
    pos_plus_step = {1'b0, bar_pos} + {1'b0, step};
    lo_plus_step  = {1'b0, lo} + {1'b0, step};
    next_pos      = bar_pos;
    next_dir      = dir;
    hit_limit     = 1'b0;
    if (!dir) begin
      if (pos_plus_step >= {1'b0, hi}) begin
        next_pos  = hi;
        next_dir  = 1'b1;
        hit_limit = 1'b1;
      end else begin
        next_pos = pos_plus_step[POS_W-1:0];
      end
    end else begin
      if ({1'b0, bar_pos} <= lo_plus_step) begin
        next_pos  = lo;
        next_dir  = 1'b0;
        hit_limit = 1'b1;
      end else begin
        next_pos = bar_pos - step;
      end
    end
  end

  // Current position pulled into the limits carried by the incoming config.
  always_comb begin
    clamp_pos = bar_pos;
    if (bar_pos < cfg.cfg_lo) begin
      clamp_pos = cfg.cfg_lo;
    end else if (bar_pos > cfg.cfg_hi) begin
      clamp_pos = cfg.cfg_hi;
    end
  end

  // Sweep FSM with registered outputs; a config transfer takes priority over
  // the frame_start of the same cycle, which is then discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bar_pos     <= POS_W'(LO_DEFAULT);
      bar_width   <= POS_W'(WIDTH_DEFAULT);
      dir         <= 1'b0;
      lo          <= POS_W'(LO_DEFAULT);
      hi          <= POS_W'(HI_DEFAULT);
      step        <= POS_W'(STEP_DEFAULT);
      frame_cnt   <= '0;
      cfg.cfg_err <= 1'b0;
      pos_update  <= 1'b0;
`ifdef DWELL_EN
      dwell_cnt   <= '0;
`endif
    end else begin
      pos_update  <= 1'b0;
      cfg.cfg_err <= 1'b0;
      if (cfg_fire) begin
        if (cfg_legal) begin
          lo         <= cfg.cfg_lo;
          hi         <= cfg.cfg_hi;
          step       <= cfg.cfg_step;
          bar_width  <= cfg.cfg_width;
          bar_pos    <= clamp_pos;
          pos_update <= (clamp_pos != bar_pos);
          frame_cnt  <= '0;
          state      <= run ? WAIT : IDLE;
        end else begin
          cfg.cfg_err <= 1'b1;
          if (!run) begin
            state     <= IDLE;
            frame_cnt <= '0;
          end else if (state == IDLE) begin
            state <= WAIT;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (run) state <= WAIT;
          end
          WAIT: begin
            if (!run) begin
              state     <= IDLE;
              frame_cnt <= '0;
            end else if (frame_start) begin
              if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                state     <= STEP;
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end
          end
          STEP: begin
            bar_pos    <= next_pos;
            dir        <= next_dir;
            pos_update <= 1'b1;
            if (!run) begin
              state <= IDLE;
            end else begin
`ifdef DWELL_EN
              state     <= hit_limit ? DWELL : WAIT;
              dwell_cnt <= '0;
`else
              state <= WAIT;
`endif
            end
          end
`ifdef DWELL_EN
          DWELL: begin
            if (!run) begin
              state <= IDLE;
            end else if (frame_start) begin
              if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                state     <= WAIT;
              end else begin
                dwell_cnt <= dwell_cnt + 16'd1;
              end
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef DWELL_EN
  // Limit detection only matters when the bar dwells at a limit.
  logic unused_hit;
  assign unused_hit = hit_limit;
`endif

endmodule
